// File: rtl/dm_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA/debug loader, the data
// memory and dm_arbiter. The arbiter connects through the slave modport;
// the requester/memory side (or a bench) uses the master modport.
interface dm_arbiter_if #(
  parameter int LEN_W = 4
);
  // CPU MEM-stage port
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       cpu_type;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic [31:0]      cpu_rdata;

  // DMA / debug loader port
  logic             dma_req;
  logic             dma_we;
  logic [31:0]      dma_addr;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_wdata;
  logic             dma_beat_ack;
  logic [31:0]      dma_rdata;
  logic             dma_done;

  // Data memory port
  logic             mem_we;
  logic [2:0]       mem_type;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_beat_ack, dma_rdata, dma_done,
    output mem_we, mem_type, mem_addr, mem_wdata,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_beat_ack, dma_rdata, dma_done,
    input  mem_we, mem_type, mem_addr, mem_wdata,
    output mem_dout
  );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: the CPU owns dm by default; a DMA grant opens a
// fixed-length word burst with arbiter-generated addresses. An aging
// counter forces a DMA grant after MAX_WAIT contended cycles.
module dm_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rstn,
  dm_arbiter_if.slave bus
);

  localparam logic [2:0] DM_WORD = 3'b000;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state, state_n;
  logic [31:0]      base, base_n;
  logic [LEN_W-1:0] beat, beat_n;
  logic [LEN_W-1:0] last, last_n;
  logic             we_l, we_l_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

  logic             wait_full;
  logic             dma_win;
  logic [LEN_W-1:0] len_m1;
  logic [31:0]      beat_off;

  // Derived helpers: aging threshold, clamped burst length, beat byte offset.
  always_comb begin
    wait_full = (wait_cnt == CNT_W'(MAX_WAIT));
    len_m1    = (bus.dma_len == '0) ? '0 : bus.dma_len - LEN_W'(1);
    beat_off  = {{(30 - LEN_W){1'b0}}, beat, 2'b00};
  end

  // Grant decision, memory mux, handshake outputs and next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_n          = state;
    base_n           = base;
    beat_n           = beat;
    last_n           = last;
    we_l_n           = we_l;
    wait_cnt_n       = wait_cnt;
    dma_win          = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_type     = bus.cpu_type;
    bus.mem_addr     = bus.cpu_addr;
    bus.mem_wdata    = bus.cpu_wdata;
    bus.cpu_gnt      = 1'b0;
    bus.dma_beat_ack = 1'b0;
    bus.dma_done     = 1'b0;

    unique case (state)
      IDLE: begin
        dma_win = bus.dma_req & (~bus.cpu_req | wait_full);
        if (dma_win) begin
          // First beat goes out in the acceptance cycle from the raw address.
          bus.mem_type     = DM_WORD;
          bus.mem_addr     = {bus.dma_addr[31:2], 2'b00};
          bus.mem_we       = bus.dma_we;
          bus.mem_wdata    = bus.dma_wdata;
          bus.dma_beat_ack = 1'b1;
          base_n           = {bus.dma_addr[31:2], 2'b00};
          we_l_n           = bus.dma_we;
          last_n           = len_m1;
          beat_n           = LEN_W'(1);
          wait_cnt_n       = '0;
          if (len_m1 == '0) begin
            bus.dma_done = 1'b1;
          end else begin
            state_n = BURST;
          end
        end else begin
          if (bus.cpu_req) begin
            bus.mem_we  = bus.cpu_we;
            bus.cpu_gnt = 1'b1;
          end
          // Age only while the DMA is actually being held off by the CPU.
          if (!bus.dma_req) begin
            wait_cnt_n = '0;
          end else if (bus.cpu_req && !wait_full) begin
            wait_cnt_n = wait_cnt + CNT_W'(1);
          end
        end
      end

      BURST: begin
        dma_win          = 1'b1;
        bus.mem_type     = DM_WORD;
        bus.mem_addr     = base + beat_off;
        bus.mem_we       = we_l;
        bus.mem_wdata    = bus.dma_wdata;
        bus.dma_beat_ack = 1'b1;
        beat_n           = beat + LEN_W'(1);
        wait_cnt_n       = '0;
        if (beat == last) begin
          bus.dma_done = 1'b1;
          state_n      = IDLE;
          beat_n       = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Reset gates everything that could commit or be mistaken for a beat.
    if (!rstn) begin
      bus.mem_we       = 1'b0;
      bus.cpu_gnt      = 1'b0;
      bus.dma_beat_ack = 1'b0;
      bus.dma_done     = 1'b0;
    end

    bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt;
    bus.cpu_rdata = bus.mem_dout;
    bus.dma_rdata = bus.mem_dout;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state    <= IDLE;
      beat     <= '0;
      wait_cnt <= '0;
      we_l     <= 1'b0;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      wait_cnt <= wait_cnt_n;
      we_l     <= we_l_n;
    end
  end

  // Burst descriptor registers, only meaningful once a burst is accepted.
  always_ff @(posedge clk) begin
    // NOTE: base and last are pure datapath, always rewritten on acceptance
    // before being read, so they carry no reset.
    if (rstn) begin
      base <= base_n;
      last <= last_n;
    end
  end

endmodule
